mac_cfg_loader: RTL

- Writer side of the MAC quad-cluster configuration bus.
- Receives a config frame as a narrow valid/ready beat stream and assembles it in a shadow register. It then commits the frame atomically to the cluster's wide cfg bus: 4 × initial accumulator values + shared config bits.
- Sequences the cluster through a reload so that the new initial values are loaded.
- Placed between the fabric configuration network and one mac_cluster.

---
 rtl/mac_cfg_loader_pkg.sv | 35 +++
 rtl/mac_cfg_shifter.sv | 63 ++++++
 rtl/mac_cfg_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_cfg_loader_pkg.sv
// Shared constants, default widths and FSM encoding for the MAC cluster config loader.
// Defining MAC_CFG_READBACK_EN in the build adds the cfg readback stream to mac_cfg_loader.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 8
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 8
`endif
`ifndef MAC_CFG_DIN_W
`define MAC_CFG_DIN_W 8
`endif
`ifndef MAC_CFG_W
`define MAC_CFG_W (4*`MAC_ACC_WIDTH + `MAC_CONF_WIDTH)
`endif

package mac_cfg_loader_pkg;

   typedef enum logic [2:0] {
      MAC_CFG_ST_IDLE   = 3'd0,
      MAC_CFG_ST_LOAD   = 3'd1,
      MAC_CFG_ST_COMMIT = 3'd2,
      MAC_CFG_ST_RELOAD = 3'd3,
      MAC_CFG_ST_DRAIN  = 3'd4
   } mac_cfg_state_e;

   function automatic int cfg_beats(input int cfg_w, input int din_w);
      return (cfg_w + din_w - 1) / din_w;
   endfunction

   // A single-beat frame still needs a one-bit counter to keep port widths legal.
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/mac_cfg_shifter.sv
// Beat counter plus shadow register: assembles a frame from indexed beat writes, or is
// parallel-loaded and stepped beat by beat when used as a serialiser.
module mac_cfg_shifter
   import mac_cfg_loader_pkg::*;
#(
   parameter int CFG_W = 40,
   parameter int DIN_W = 8,
   parameter int BEATS = 5,
   parameter int CNT_W = cnt_width(BEATS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [DIN_W-1:0] wr_data,
   input  logic             load_en,
   input  logic [CFG_W-1:0] load_data,
   input  logic             adv_en,
   output logic [CFG_W-1:0] shadow,
   output logic [CNT_W-1:0] count
);

   logic [CFG_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             at_last;

   // Bits of the final beat that fall beyond CFG_W have no storage and are dropped.
   always_comb begin
      shadow_d = shadow_q;
      count_d  = count_q;
      at_last  = (count_q == CNT_W'(BEATS - 1));
      if (clear) begin
         shadow_d = '0;
         count_d  = '0;
      end else if (load_en) begin
         shadow_d = load_data;
         count_d  = '0;
      end else if (wr_en || adv_en) begin
         if (wr_en) begin
            for (int i = 0; i < CFG_W; i++) begin
               if (CNT_W'(i / DIN_W) == count_q) begin
                  shadow_d[i] = wr_data[i % DIN_W];
               end
            end
         end
         count_d = at_last ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
         count_q  <= '0;
      end else begin
         shadow_q <= shadow_d;
         count_q  <= count_d;
      end
   end

   assign shadow = shadow_q;
   assign count  = count_q;

endmodule

// File: rtl/mac_cfg_loader.sv
// Config-bus writer for one mac_cluster: assembles beat frames, commits them atomically and
// pulses the cluster reset. Defining MAC_CFG_READBACK_EN adds a serial readback of cfg.
module mac_cfg_loader
   import mac_cfg_loader_pkg::*;
#(
   parameter  int ACC_W  = `MAC_ACC_WIDTH,
   parameter  int CONF_W = `MAC_CONF_WIDTH,
   parameter  int DIN_W  = `MAC_CFG_DIN_W,
   localparam int CFG_W  = 4 * ACC_W + CONF_W,
   localparam int BEATS  = cfg_beats(CFG_W, DIN_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic [DIN_W-1:0] din_data,
   input  logic             din_last,
   input  logic             en_in,
   output logic [CFG_W-1:0] cfg,
   output logic             cfg_valid,
   output logic             cluster_rst,
   output logic             cluster_en,
   output logic             frame_err,
   input  logic             err_clr
`ifdef MAC_CFG_READBACK_EN
   ,
   input  logic             rb_req,
   output logic             rb_valid,
   input  logic             rb_ready,
   output logic [DIN_W-1:0] rb_data,
   output logic             rb_last
`endif
);

   localparam int CNT_W = cnt_width(BEATS);

   mac_cfg_state_e   state_q, state_d;
   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic             cfg_valid_q, cfg_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             din_ready_q, din_ready_d;
   logic             cluster_rst_q, cluster_rst_d;
   logic             cluster_en_q, cluster_en_d;

   logic             accept;
   logic             cnt_last;
   logic             set_err;
   logic             rb_busy;
   logic             shf_clear;
   logic             shf_wr;
   logic             shf_load;
   logic             shf_adv;
   logic [CFG_W-1:0] shf_load_data;
   logic [CFG_W-1:0] shf_shadow;
   logic [CNT_W-1:0] shf_count;

`ifdef MAC_CFG_READBACK_EN
   logic             rb_active_q, rb_active_d;
   logic             rb_start;
   logic             rb_fire;
   logic [DIN_W-1:0] rb_data_c;
   int               rb_idx;
`endif

   // Readback reuses the same shifter; it only starts in IDLE, where the shadow holds nothing live.
   mac_cfg_shifter #(
      .CFG_W (CFG_W),
      .DIN_W (DIN_W),
      .BEATS (BEATS),
      .CNT_W (CNT_W)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .clear     (shf_clear),
      .wr_en     (shf_wr),
      .wr_data   (din_data),
      .load_en   (shf_load),
      .load_data (shf_load_data),
      .adv_en    (shf_adv),
      .shadow    (shf_shadow),
      .count     (shf_count)
   );

   always_comb begin
      state_d       = state_q;
      cfg_d         = cfg_q;
      cfg_valid_d   = cfg_valid_q;
      set_err       = 1'b0;
      shf_clear     = 1'b0;
      shf_wr        = 1'b0;
      shf_load      = 1'b0;
      shf_adv       = 1'b0;
      shf_load_data = '0;
      accept        = din_valid & din_ready_q;
      cnt_last      = (shf_count == CNT_W'(BEATS - 1));

      case (state_q)
         MAC_CFG_ST_IDLE, MAC_CFG_ST_LOAD: begin
            if (accept) begin
               if (din_last && cnt_last) begin
                  shf_wr  = 1'b1;
                  state_d = MAC_CFG_ST_COMMIT;
               end else if (din_last) begin
                  set_err   = 1'b1;
                  shf_clear = 1'b1;
                  state_d   = MAC_CFG_ST_IDLE;
               end else if (cnt_last) begin
                  set_err   = 1'b1;
                  shf_clear = 1'b1;
                  state_d   = MAC_CFG_ST_DRAIN;
               end else begin
                  shf_wr  = 1'b1;
                  state_d = MAC_CFG_ST_LOAD;
               end
            end
         end
         MAC_CFG_ST_DRAIN: begin
            if (accept && din_last) begin
               state_d = MAC_CFG_ST_IDLE;
            end
         end
         MAC_CFG_ST_COMMIT: begin
            cfg_d       = shf_shadow;
            cfg_valid_d = 1'b1;
            state_d     = MAC_CFG_ST_RELOAD;
         end
         MAC_CFG_ST_RELOAD: begin
            state_d = MAC_CFG_ST_IDLE;
         end
         default: begin
            state_d = MAC_CFG_ST_IDLE;
         end
      endcase

`ifdef MAC_CFG_READBACK_EN
      rb_start      = rb_req & (state_q == MAC_CFG_ST_IDLE) & ~rb_active_q & ~accept;
      rb_fire       = rb_active_q & rb_ready;
      shf_load      = rb_start;
      shf_load_data = cfg_q;
      shf_adv       = rb_fire;
      rb_active_d   = rb_start | (rb_active_q & ~(rb_fire & cnt_last));
      rb_busy       = rb_active_d;
`else
      rb_busy       = 1'b0;
`endif

      // Outputs are computed from the next state so each flop lines up with its state's cycle.
      frame_err_d   = set_err | (frame_err_q & ~err_clr);
      din_ready_d   = (state_d inside {MAC_CFG_ST_IDLE, MAC_CFG_ST_LOAD, MAC_CFG_ST_DRAIN}) & ~rb_busy;
      cluster_rst_d = (state_d == MAC_CFG_ST_RELOAD);
      cluster_en_d  = en_in & cfg_valid_d &
                      ~(state_d inside {MAC_CFG_ST_COMMIT, MAC_CFG_ST_RELOAD});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= MAC_CFG_ST_IDLE;
         cfg_q         <= '0;
         cfg_valid_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         din_ready_q   <= 1'b0;
         cluster_rst_q <= 1'b1;
         cluster_en_q  <= 1'b0;
`ifdef MAC_CFG_READBACK_EN
         rb_active_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cfg_q         <= cfg_d;
         cfg_valid_q   <= cfg_valid_d;
         frame_err_q   <= frame_err_d;
         din_ready_q   <= din_ready_d;
         cluster_rst_q <= cluster_rst_d;
         cluster_en_q  <= cluster_en_d;
`ifdef MAC_CFG_READBACK_EN
         rb_active_q   <= rb_active_d;
`endif
      end
   end

`ifdef MAC_CFG_READBACK_EN
   // Padding bits past CFG_W in the final readback beat are driven as zero.
   always_comb begin
      rb_data_c = '0;
      rb_idx    = 0;
      for (int j = 0; j < DIN_W; j++) begin
         rb_idx = int'(shf_count) * DIN_W + j;
         if (rb_idx < CFG_W) begin
            rb_data_c[j] = shf_shadow[rb_idx];
         end
      end
   end

   assign rb_valid = rb_active_q;
   assign rb_last  = rb_active_q & cnt_last;
   assign rb_data  = rb_data_c;
`endif

   assign din_ready   = din_ready_q;
   assign cfg         = cfg_q;
   assign cfg_valid   = cfg_valid_q;
   assign cluster_rst = cluster_rst_q;
   assign cluster_en  = cluster_en_q;
   assign frame_err   = frame_err_q;

endmodule
